// File: rtl/ez8_prog_loader.sv
// ez8_prog_loader
//   Turns a framed byte stream from the host link into 16-bit instruction
//   words for the ez8 core. The core is held paused while it loads. After a
//   good load the core gets a reset pulse, so its PC restarts at 0.
//
//   Frame: HEADER, LEN_HI, LEN_LO, N x {hi, lo}, [CSUM]
//   N = {LEN_HI[3:0], LEN_LO}
//
//   Build option EZ8_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   rx_data, rx_valid       incoming byte and its 1-cycle strobe
//   instr_writeaddr/data/en instruction memory write port (registered)
//   cpu_pause, cpu_reset    core hold and core reset pulse
//   load_done, load_error   sticky load status, cleared by the next header
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for HEADER_BYTE, all other bytes dropped
// LENH  | expecting LEN_HI (upper nibble must be zero)
// LENL  | expecting LEN_LO
// DHI   | expecting the high byte of a word
// DLO   | expecting the low byte; the word is written on the next cycle
// CSUM  | expecting the checksum byte (checksum build only)
// RST   | cpu_reset pulse running, rx ignored
// ERR   | aborted load, one cycle, then IDLE with the core still held

module ez8_prog_loader #(
   parameter int          TIMEOUT_CYCLES = 1000000,
   parameter int          RESET_CYCLES   = 4,
   parameter logic [7:0]  HEADER_BYTE    = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [11:0] instr_writeaddr,
   output logic [15:0] instr_writedata,
   output logic        instr_write_en,
   output logic        cpu_pause,
   output logic        cpu_reset,
   output logic        load_done,
   output logic        load_error
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    RST_LOAD = 4'(RESET_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LENH, S_LENL, S_DHI, S_DLO,
`ifdef EZ8_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_RST, S_ERR
   } state_t;

   state_t state, state_nxt;

   logic [3:0]    len_hi_q;
   logic [11:0]   last_idx;
   logic [11:0]   word_cnt;
   logic [7:0]    hi_q;
   logic [3:0]    rst_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [11:0]   len_n;
   logic          in_frame;
   logic          tmo_hit;
   logic          hdr, wr, rst_end;

`ifdef EZ8_LOADER_CHECKSUM_EN
   logic [7:0] csum;
   localparam state_t S_END = S_CSUM;
   assign in_frame = (state inside {S_LENH, S_LENL, S_DHI, S_DLO, S_CSUM});
`else
   localparam state_t S_END = S_RST;
   assign in_frame = (state inside {S_LENH, S_LENL, S_DHI, S_DLO});
`endif

   assign len_n   = {len_hi_q, rx_data};
   assign tmo_hit = (TIMEOUT_CYCLES != 0) && in_frame && !rx_valid && (tmo_cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      hdr       = 1'b0;
      wr        = 1'b0;
      rst_end   = 1'b0;
      case (state)
         S_IDLE: if (rx_valid && rx_data == HEADER_BYTE) begin
            hdr       = 1'b1;
            state_nxt = S_LENH;
         end
         S_LENH: if (rx_valid) state_nxt = (rx_data[7:4] != 4'd0) ? S_ERR : S_LENL;
         S_LENL: if (rx_valid) state_nxt = (len_n == 12'd0) ? S_END : S_DHI;
         S_DHI:  if (rx_valid) state_nxt = S_DLO;
         S_DLO:  if (rx_valid) begin
            wr        = 1'b1;
            state_nxt = (word_cnt == last_idx) ? S_END : S_DHI;
         end
`ifdef EZ8_LOADER_CHECKSUM_EN
         S_CSUM: if (rx_valid) state_nxt = (rx_data == csum) ? S_RST : S_ERR;
`endif
         S_RST: if (rst_cnt == 4'd0) begin
            rst_end   = 1'b1;
            state_nxt = S_IDLE;
         end
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (tmo_hit) state_nxt = S_ERR;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_writeaddr <= '0;
         instr_writedata <= '0;
         instr_write_en  <= 1'b0;
         cpu_pause       <= 1'b0;
         cpu_reset       <= 1'b0;
         load_done       <= 1'b0;
         load_error      <= 1'b0;
         len_hi_q        <= '0;
         last_idx        <= '0;
         word_cnt        <= '0;
         hi_q            <= '0;
         rst_cnt         <= '0;
         tmo_cnt         <= '0;
      end else begin
         instr_write_en <= wr;
         if (wr) begin
            instr_writeaddr <= word_cnt;
            instr_writedata <= {hi_q, rx_data};
            word_cnt        <= word_cnt + 12'd1;
         end
         if (hdr) begin
            cpu_pause  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            word_cnt   <= '0;
         end
         if (state == S_LENH && rx_valid) len_hi_q <= rx_data[3:0];
         if (state == S_LENL && rx_valid) last_idx <= len_n - 12'd1;
         if (state == S_DHI  && rx_valid) hi_q     <= rx_data;

         // Idle-gap timer restarts on every byte; only counts inside a frame.
         if (hdr || rx_valid)
            tmo_cnt <= TMO_LOAD;
         else if (in_frame && tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - 1'b1;

         if (state_nxt == S_RST && state != S_RST) begin
            cpu_reset <= 1'b1;
            rst_cnt   <= RST_LOAD;
         end else if (state == S_RST && rst_cnt != 4'd0) begin
            rst_cnt <= rst_cnt - 4'd1;
         end

         // The core is released only here; an aborted load leaves it held.
         if (rst_end) begin
            cpu_reset <= 1'b0;
            cpu_pause <= 1'b0;
            load_done <= 1'b1;
         end
         if (state_nxt == S_ERR) load_error <= 1'b1;
      end
   end

`ifdef EZ8_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset || hdr)
         csum <= '0;
      else if (rx_valid && (state inside {S_LENH, S_LENL, S_DHI, S_DLO}))
         csum <= csum ^ rx_data;
   end
`endif

endmodule

// File: tb/tb_ez8_prog_loader.sv
module tb_ez8_prog_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [11:0] instr_writeaddr;
   logic [15:0] instr_writedata;
   logic        instr_write_en;
   logic        cpu_pause;
   logic        cpu_reset;
   logic        load_done;
   logic        load_error;

   int checks = 0;
   int errors = 0;

   int          wr_cnt = 0;
   int          rst_hi = 0;
   logic [11:0] wa[$];
   logic [15:0] wd[$];

   int w0;
   int r0;

   ez8_prog_loader #(
      .TIMEOUT_CYCLES(16),
      .RESET_CYCLES(4),
      .HEADER_BYTE(8'hA5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .instr_writeaddr(instr_writeaddr),
      .instr_writedata(instr_writedata),
      .instr_write_en(instr_write_en),
      .cpu_pause(cpu_pause),
      .cpu_reset(cpu_reset),
      .load_done(load_done),
      .load_error(load_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (instr_write_en) begin
         wr_cnt++;
         wa.push_back(instr_writeaddr);
         wd.push_back(instr_writedata);
      end
      if (cpu_reset) rst_hi++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_csum(input logic [7:0] c);
`ifdef EZ8_LOADER_CHECKSUM_EN
      send_byte(c);
`else
      c = c;
`endif
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_end(input string tag);
      int k;
      k = 0;
      while (!(load_done || load_error) && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (k >= 40) chk(tag, 32'd0, 32'd1);
   endtask

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(3);
      chk("reset_outputs", {3'b0, instr_write_en, cpu_pause, cpu_reset, load_done,
                            load_error, instr_writeaddr, instr_writedata}, 32'd0);
      reset = 1'b0;
      idle(2);

      // Test 1: two-word good frame
      w0 = wr_cnt; r0 = rst_hi;
      send_byte(8'hA5);
      chk("t1_pause_on_header", cpu_pause, 1);
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34);
      send_byte(8'hAB); send_byte(8'hCD);
      send_csum(8'h42);
      wait_end("t1_wait");
      chk("t1_done", load_done, 1);
      chk("t1_error", load_error, 0);
      chk("t1_pause", cpu_pause, 0);
      chk("t1_nwrites", wr_cnt - w0, 2);
      chk("t1_addr0", wa[w0], 12'h000);
      chk("t1_data0", wd[w0], 16'h1234);
      chk("t1_addr1", wa[w0+1], 12'h001);
      chk("t1_data1", wd[w0+1], 16'hABCD);
      chk("t1_rst_cycles", rst_hi - r0, 4);

`ifdef EZ8_LOADER_CHECKSUM_EN
      // Test 2: bad checksum
      w0 = wr_cnt; r0 = rst_hi;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34);
      send_byte(8'hAB); send_byte(8'hCD);
      send_byte(8'h43);
      wait_end("t2_wait");
      idle(6);
      chk("t2_error", load_error, 1);
      chk("t2_done", load_done, 0);
      chk("t2_pause", cpu_pause, 1);
      chk("t2_nwrites", wr_cnt - w0, 2);
      chk("t2_no_rst", rst_hi - r0, 0);
`endif

      // Test 3: LEN_HI upper nibble set
      w0 = wr_cnt;
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
      wait_end("t3_wait");
      chk("t3_error", load_error, 1);
      chk("t3_done", load_done, 0);
      chk("t3_pause", cpu_pause, 1);
      chk("t3_nwrites", wr_cnt - w0, 0);

      // Test 4: empty frame; header clears the error flag
      w0 = wr_cnt; r0 = rst_hi;
      send_byte(8'hA5);
      chk("t4_err_cleared", load_error, 0);
      chk("t4_pause", cpu_pause, 1);
      send_byte(8'h00); send_byte(8'h00);
      send_csum(8'h00);
      wait_end("t4_wait");
      chk("t4_done", load_done, 1);
      chk("t4_pause_off", cpu_pause, 0);
      chk("t4_nwrites", wr_cnt - w0, 0);
      chk("t4_rst_cycles", rst_hi - r0, 4);

      // Test 5: timeout after 16 idle cycles, then a good frame
      w0 = wr_cnt;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
      idle(15);
      chk("t5_no_err_at_15", load_error, 0);
      idle(1);
      chk("t5_err_at_16", load_error, 1);
      chk("t5_pause", cpu_pause, 1);
      chk("t5_nwrites", wr_cnt - w0, 0);
      w0 = wr_cnt;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hBE); send_byte(8'hEF);
      send_csum(8'h50);
      wait_end("t5b_wait");
      chk("t5b_done", load_done, 1);
      chk("t5b_error", load_error, 0);
      chk("t5b_nwrites", wr_cnt - w0, 1);
      chk("t5b_data", wd[w0], 16'hBEEF);

      // Test 6: reset while waiting for the low byte of word 3 of 8
      w0 = wr_cnt;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h08);
      for (int i = 0; i < 3; i++) begin
         send_byte(8'h10 + 8'(i));
         send_byte(8'h20 + 8'(i));
      end
      send_byte(8'h13);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      chk("t6_outputs_zero", {3'b0, instr_write_en, cpu_pause, cpu_reset, load_done,
                              load_error, instr_writeaddr, instr_writedata}, 32'd0);
      chk("t6_nwrites", wr_cnt - w0, 3);
      chk("t6_addr2", wa[w0+2], 12'h002);
      chk("t6_data2", wd[w0+2], 16'h1222);
      send_byte(8'h12);
      idle(3);
      chk("t6_idle_pause", cpu_pause, 0);
      chk("t6_idle_nwrites", wr_cnt - w0, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
